// File: rtl/processing_unit_gen.sv
// rtl/processing_unit_gen.sv - NoC tile processing element: burst TX through master grant, RX sequence checker
module processing_unit_gen #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 2,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tb_request,
  input  logic [DEST_W-1:0] tb_processor,
  input  logic [LEN_W-1:0]  tb_len,
  input  logic              master_response,
  input  logic              tx_ready,
  output logic [DATA_W:0]   data_to_router,
  output logic              tx_valid,
  output logic              request_transfer,
  output logic [DEST_W-1:0] which_processor,
  output logic              processor_ready,
  input  logic [DATA_W:0]   data_from_router,
  input  logic              rx_valid,
  output logic [CNT_W-1:0]  rx_packet_count,
  output logic              rx_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  seq_q, seq_d;
  logic [DATA_W:0]   flit_q, flit_d;
  logic              tx_valid_q, tx_valid_d;
  logic              req_q, req_d;

  logic [DATA_W-1:0] rx_expect_q, rx_expect_d;
  logic [CNT_W-1:0]  rx_count_q, rx_count_d;
  logic              rx_error_q, rx_error_d;

  // Zero-extend before slicing so the payload works for any DATA_W vs LEN_W ratio.
  function automatic logic [DATA_W:0] make_flit(input logic [LEN_W-1:0] s,
                                                input logic [LEN_W-1:0] l);
    logic [DATA_W+LEN_W-1:0] ext;
    ext = {{DATA_W{1'b0}}, s};
    return {(s == l), ext[DATA_W-1:0]};
  endfunction

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    len_d      = len_q;
    seq_d      = seq_q;
    flit_d     = flit_q;
    tx_valid_d = tx_valid_q;
    req_d      = req_q;
    case (state_q)
      IDLE: begin
        if (tb_request && (tb_len != '0)) begin
          dest_d  = tb_processor;
          len_d   = tb_len;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (master_response) begin
          req_d      = 1'b0;
          seq_d      = LEN_W'(1);
          flit_d     = make_flit(LEN_W'(1), len_q);
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (flit_q[DATA_W]) begin
            tx_valid_d = 1'b0;
            flit_d     = '0;
            state_d    = DONE;
          end else begin
            seq_d  = seq_q + LEN_W'(1);
            flit_d = make_flit(seq_q + LEN_W'(1), len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_expect_d = rx_expect_q;
    rx_count_d  = rx_count_q;
    rx_error_d  = rx_error_q;
    if (rx_valid) begin
      if (data_from_router[DATA_W-1:0] != rx_expect_q) rx_error_d = 1'b1;
      if (data_from_router[DATA_W]) begin
        rx_expect_d = DATA_W'(1);
        if (rx_count_q != '1) rx_count_d = rx_count_q + CNT_W'(1);
      end else begin
        rx_expect_d = rx_expect_q + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      len_q       <= '0;
      seq_q       <= LEN_W'(1);
      flit_q      <= '0;
      tx_valid_q  <= 1'b0;
      req_q       <= 1'b0;
      rx_expect_q <= DATA_W'(1);
      rx_count_q  <= '0;
      rx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      seq_q       <= seq_d;
      flit_q      <= flit_d;
      tx_valid_q  <= tx_valid_d;
      req_q       <= req_d;
      rx_expect_q <= rx_expect_d;
      rx_count_q  <= rx_count_d;
      rx_error_q  <= rx_error_d;
    end
  end

  assign data_to_router   = flit_q;
  assign tx_valid         = tx_valid_q;
  assign request_transfer = req_q;
  assign which_processor  = dest_q;
  assign processor_ready  = (state_q == IDLE);
  assign rx_packet_count  = rx_count_q;
  assign rx_error         = rx_error_q;

endmodule

// File: tb/tb_processing_unit_gen.sv
// tb/tb_processing_unit_gen.sv - directed self-checking bench for processing_unit_gen
module tb_processing_unit_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        tb_request;
  logic [1:0]  tb_processor;
  logic [7:0]  tb_len;
  logic        master_response;
  logic        tx_ready;
  logic [8:0]  data_to_router;
  logic        tx_valid;
  logic        request_transfer;
  logic [1:0]  which_processor;
  logic        processor_ready;
  logic [8:0]  data_from_router;
  logic        rx_valid;
  logic [15:0] rx_packet_count;
  logic        rx_error;

  int checks = 0;
  int errors = 0;

  processing_unit_gen #(.DATA_W(8), .DEST_W(2), .LEN_W(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .tb_request(tb_request), .tb_processor(tb_processor), .tb_len(tb_len),
    .master_response(master_response), .tx_ready(tx_ready),
    .data_to_router(data_to_router), .tx_valid(tx_valid),
    .request_transfer(request_transfer), .which_processor(which_processor),
    .processor_ready(processor_ready),
    .data_from_router(data_from_router), .rx_valid(rx_valid),
    .rx_packet_count(rx_packet_count), .rx_error(rx_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check_tx_reset(input string tag);
    check({tag, ".data"}, 16'(data_to_router), 16'h000);
    check({tag, ".tx_valid"}, 16'(tx_valid), 16'd0);
    check({tag, ".req"}, 16'(request_transfer), 16'd0);
    check({tag, ".which"}, 16'(which_processor), 16'd0);
    check({tag, ".ready"}, 16'(processor_ready), 16'd1);
  endtask

  // Issue a request, check the REQ phase, grant one cycle after request_transfer rises.
  task automatic start_burst(input logic [1:0] dest, input logic [7:0] len);
    tb_request = 1'b1; tb_processor = dest; tb_len = len;
    step();
    tb_request = 1'b0;
    check("req.rise", 16'(request_transfer), 16'd1);
    check("req.which", 16'(which_processor), 16'(dest));
    check("req.ready", 16'(processor_ready), 16'd0);
    step();
    check("req.hold", 16'(request_transfer), 16'd1);
    master_response = 1'b1;
    step();
    master_response = 1'b0;
    check("grant.req_low", 16'(request_transfer), 16'd0);
  endtask

  task automatic expect_flit(input string tag, input logic [8:0] exp, input logic [1:0] dest);
    check({tag, ".valid"}, 16'(tx_valid), 16'd1);
    check({tag, ".data"}, 16'(data_to_router), 16'(exp));
    check({tag, ".which"}, 16'(which_processor), 16'(dest));
  endtask

  task automatic expect_done_then_idle(input string tag);
    check({tag, ".done_valid"}, 16'(tx_valid), 16'd0);
    check({tag, ".done_ready"}, 16'(processor_ready), 16'd0);
    step();
    check({tag, ".idle_ready"}, 16'(processor_ready), 16'd1);
  endtask

  task automatic rx_send(input logic [8:0] flit);
    data_from_router = flit; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tb_request = 1'b0; tb_processor = '0; tb_len = '0;
    master_response = 1'b0; tx_ready = 1'b1; data_from_router = '0; rx_valid = 1'b0;
    step();
    check_tx_reset("rst");
    check("rst.rx_count", rx_packet_count, 16'd0);
    check("rst.rx_error", 16'(rx_error), 16'd0);
    reset = 1'b0;
    step();

    // Basic burst dest=2 len=4
    start_burst(2'd2, 8'd4);
    expect_flit("b1.f1", 9'h001, 2'd2); step();
    expect_flit("b1.f2", 9'h002, 2'd2); step();
    expect_flit("b1.f3", 9'h003, 2'd2); step();
    expect_flit("b1.f4", 9'h104, 2'd2); step();
    expect_done_then_idle("b1");
    check("b1.which_kept", 16'(which_processor), 16'd2);

    // Same burst, router stalls 3 cycles on flit 2
    start_burst(2'd2, 8'd4);
    expect_flit("b2.f1", 9'h001, 2'd2); step();
    expect_flit("b2.f2a", 9'h002, 2'd2); tx_ready = 1'b0; step();
    expect_flit("b2.f2b", 9'h002, 2'd2); step();
    expect_flit("b2.f2c", 9'h002, 2'd2); step();
    expect_flit("b2.f2d", 9'h002, 2'd2); tx_ready = 1'b1; step();
    expect_flit("b2.f3", 9'h003, 2'd2); step();
    expect_flit("b2.f4", 9'h104, 2'd2); step();
    expect_done_then_idle("b2");

    // Zero-length request is ignored
    tb_request = 1'b1; tb_len = 8'd0; tb_processor = 2'd1;
    step();
    check("len0.req", 16'(request_transfer), 16'd0);
    check("len0.ready", 16'(processor_ready), 16'd1);
    step();
    tb_request = 1'b0;
    check("len0.req2", 16'(request_transfer), 16'd0);
    check("len0.ready2", 16'(processor_ready), 16'd1);

    // New request during SEND must not disturb a dest=1 burst
    start_burst(2'd1, 8'd3);
    expect_flit("b3.f1", 9'h001, 2'd1);
    tb_request = 1'b1; tb_processor = 2'd3; tb_len = 8'd5;
    step();
    expect_flit("b3.f2", 9'h002, 2'd1);
    tb_request = 1'b0;
    step();
    expect_flit("b3.f3", 9'h103, 2'd1); step();
    expect_done_then_idle("b3");
    check("b3.which_kept", 16'(which_processor), 16'd1);
    check("b3.no_req", 16'(request_transfer), 16'd0);

    // Reset while the 3rd of 8 flits is pending
    start_burst(2'd2, 8'd8);
    expect_flit("b4.f1", 9'h001, 2'd2); step();
    expect_flit("b4.f2", 9'h002, 2'd2); step();
    expect_flit("b4.f3", 9'h003, 2'd2);
    tx_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_tx_reset("abort_async");
    step();
    check_tx_reset("abort");
    reset = 1'b0; tx_ready = 1'b1;
    step();
    check_tx_reset("abort_idle");
    start_burst(2'd3, 8'd2);
    expect_flit("b5.f1", 9'h001, 2'd3); step();
    expect_flit("b5.f2", 9'h102, 2'd3); step();
    expect_done_then_idle("b5");

    // RX checker
    rx_send(9'h001);
    rx_send(9'h102);
    check("rx.count1", rx_packet_count, 16'd1);
    check("rx.err_clean", 16'(rx_error), 16'd0);
    rx_send(9'h001);
    check("rx.err_before", 16'(rx_error), 16'd0);
    rx_send(9'h003);
    check("rx.err_set", 16'(rx_error), 16'd1);
    rx_send(9'h104);
    check("rx.count2", rx_packet_count, 16'd2);
    check("rx.err_sticky", 16'(rx_error), 16'd1);
    step();
    check("rx.err_sticky2", 16'(rx_error), 16'd1);
    check("rx.count_hold", rx_packet_count, 16'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/processing_unit_gen.md
Name: processing_unit_gen

Overview:
Parametrised next-generation processing element for the NoC tile. Each instance sits beside one router.
- TX side: requests the master for a destination processor, waits for the grant, then streams a burst of flits. Each flit is {tlast, sequence payload}, with backpressure from the router.
- RX side: checks incoming bursts for sequence integrity and counts completed packets.

Parameters:
DATA_W, 8, payload width; a flit is DATA_W+1 bits with tlast as the MSB
DEST_W, 2, width of the destination processor index
LEN_W, 8, width of the burst length
CNT_W, 16, width of the received-packet counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tb_request  input  1  user request to start a burst
tb_processor  input  DEST_W  user destination index
tb_len  input  LEN_W  user burst length in flits
master_response  input  1  master grant (1 = request accepted)
tx_ready  input  1  router can accept the flit this cycle
data_to_router  output  DATA_W+1  outgoing flit {tlast, payload}
tx_valid  output  1  data_to_router is valid
request_transfer  output  1  allocation request to the master
which_processor  output  DEST_W  destination of the pending or active burst
processor_ready  output  1  processor idle, can accept tb_request
data_from_router  input  DATA_W+1  incoming flit {tlast, payload}
rx_valid  input  1  data_from_router is valid
rx_packet_count  output  CNT_W  completed packets received, saturating
rx_error  output  1  sticky sequence-mismatch flag

Behaviour:
- Clock is clock; reset is asynchronous and active-high. Reset wins over every other event.
- Reset values:
  - data_to_router=0, tx_valid=0, request_transfer=0, which_processor=0.
  - rx_packet_count=0, rx_error=0.
  - processor_ready=1; FSM in IDLE, seq=1, rx_expect=1.
- Reset asserted mid-burst aborts the burst immediately. No tlast is emitted.
- FSM states: IDLE, REQ, SEND, DONE. All outputs except processor_ready are registered. processor_ready = (state==IDLE).
- IDLE:
  - tb_request=1 and tb_len!=0 sampled: latch tb_processor to dest_r and tb_len to len_r; go to REQ.
  - Next cycle: request_transfer=1, which_processor=dest_r.
  - tb_request with tb_len==0 is ignored; FSM stays in IDLE.
- REQ:
  - request_transfer is held at 1 until master_response=1 is sampled.
  - On grant: request_transfer=0 next cycle; go to SEND with seq=1.
  - First flit valid on the cycle after the grant.
- SEND:
  - tx_valid=1; data_to_router = {seq==len_r, seq mod 2^DATA_W}.
  - Flit is transferred when tx_valid & tx_ready. On transfer, seq increments.
  - While tx_ready=0, data_to_router and tx_valid are held stable.
  - Transfer of the tlast flit: go to DONE, tx_valid=0 next cycle.
- DONE: one cycle, processor_ready=0, then IDLE.
- Timing for burst length L with tx_ready tied high:
  - Grant sampled at cycle G.
  - Flits at cycles G+1 .. G+L.
  - DONE at G+L+1.
  - processor_ready=1 at G+L+2.
- which_processor keeps dest_r from REQ through DONE. It changes only on a new IDLE->REQ.
- Ignored inputs:
  - tb_request while not in IDLE is ignored; tb_processor/tb_len changes mid-burst have no effect.
  - master_response outside REQ is ignored.
- seq is LEN_W bits; len_r can be at most 2^LEN_W-1, so seq never wraps within a burst. Payload truncates seq when DATA_W < LEN_W.
- RX checker, independent of the TX FSM:
  - On rx_valid: if payload != rx_expect[DATA_W-1:0], set rx_error; it clears only on reset.
  - rx_expect increments each valid flit. On a valid flit with tlast=1, rx_expect returns to 1.
  - On a valid flit with tlast=1, rx_packet_count increments and saturates at 2^CNT_W-1.

Test Plan:
- Reset, then tb_request=1, tb_processor=2, tb_len=4, grant one cycle after request_transfer rises, tx_ready=1 -> which_processor=2; flits 0x001,0x002,0x003,0x104 on consecutive cycles; processor_ready returns 1 two cycles after 0x104.
- Same burst with tx_ready low for 3 cycles during flit 2 -> 0x002 held stable for 4 cycles; no flit dropped or duplicated; tlast only on 0x104.
- tb_len=0 with tb_request=1 -> request_transfer stays 0, processor_ready stays 1.
- tb_request=1 with tb_processor=3 during SEND of a dest=1 burst -> which_processor stays 1, burst completes unchanged.
- Reset asserted while the 3rd of 8 flits is pending -> all outputs at reset values next cycle; the following burst starts at payload 0x001.
- RX stream 0x001,0x102 then 0x001,0x003,0x104 -> rx_packet_count=2, rx_error=1 set on 0x003 and staying 1.
